// File: rtl/regfile_pkg.sv
// Shared types and helpers for the pair-addressable register file.
// Pair p maps to {reg[2p+1], reg[2p]}.
package regfile_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREGS = 8;
  localparam int DEF_NRD   = 4;

  typedef enum logic {
    IDLE,
    UPD
  } idu_state_t;

  function automatic int pair_lo(input int p);
    return 2 * p;
  endfunction

  function automatic int pair_hi(input int p);
    return 2 * p + 1;
  endfunction

endpackage

// File: rtl/regfile_idu.sv
// Increment/decrement unit: captures a pair, then writes back value +/- 1.
// A blocked write-back is still reported as done, flagged by idu_drop.
module regfile_idu
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PW    = 2
) (
  input  logic               clk,
  input  logic               sync_res,
  input  logic               idu_req,
  input  logic [PW-1:0]      idu_sel,
  input  logic               idu_dec,
  input  logic [2*WIDTH-1:0] cap_val,
  input  logic               wb_block,
  output logic               idu_busy,
  output logic               idu_done,
  output logic               idu_drop,
  output logic [2*WIDTH-1:0] idu_out,
  output logic               wb_en,
  output logic [PW-1:0]      wb_sel,
  output logic [2*WIDTH-1:0] wb_val
);

  localparam logic [2*WIDTH-1:0] ONE =
    {{(2*WIDTH-1){1'b0}}, 1'b1};

  idu_state_t state;
  logic       dec_q;

  assign idu_busy = (state == UPD);
  assign wb_en    = (state == UPD) && !wb_block;
  assign wb_val   = dec_q ? idu_out - ONE
                          : idu_out + ONE;

  always_ff @(posedge clk) begin
    if (sync_res) begin
      state    <= IDLE;
      idu_out  <= '0;
      wb_sel   <= '0;
      dec_q    <= 1'b0;
      idu_done <= 1'b0;
      idu_drop <= 1'b0;
    end else begin
      idu_done <= 1'b0;
      idu_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (idu_req) begin
            state   <= UPD;
            idu_out <= cap_val;
            wb_sel  <= idu_sel;
            dec_q   <= idu_dec;
          end
        end
        UPD: begin
          state    <= IDLE;
          idu_done <= 1'b1;
          idu_drop <= wb_block;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_pairs.sv
// Register file with byte/pair write ports, multi-port reads and an
// IDU for pointer-pair updates. Priority: reset, pair, byte, IDU.
module regfile_pairs
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int SW = $clog2(NREGS),
  localparam int PW = $clog2(NREGS / 2)
) (
  input  logic                 CLK,
  input  logic                 SYNC_RES,
  input  logic                 wr_en,
  input  logic [SW-1:0]        wr_sel,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 pwr_en,
  input  logic [PW-1:0]        pwr_sel,
  input  logic [2*WIDTH-1:0]   pwr_data,
  input  logic [NRD*SW-1:0]    rd_sel,
  output logic [NRD*WIDTH-1:0] rd_data,
  input  logic                 idu_req,
  input  logic [PW-1:0]        idu_sel,
  input  logic                 idu_dec,
  output logic                 idu_busy,
  output logic                 idu_done,
  output logic [2*WIDTH-1:0]   idu_out,
  output logic                 idu_drop
);

  logic [WIDTH-1:0]   regs [NREGS];
  logic [SW-1:0]      cap_lo;
  logic [SW-1:0]      cap_hi;
  logic [2*WIDTH-1:0] cap_val;
  logic [2*WIDTH-1:0] wb_val;
  logic [PW-1:0]      wb_sel;
  logic               wb_en;
  logic               wb_block;

  assign cap_lo  = SW'(pair_lo(int'(idu_sel)));
  assign cap_hi  = SW'(pair_hi(int'(idu_sel)));
  assign cap_val = {regs[cap_hi], regs[cap_lo]};

  // Any bus write touching the IDU pair cancels the whole write-back.
  assign wb_block =
    (pwr_en && pwr_sel == wb_sel) ||
    (wr_en && PW'(wr_sel >> 1) == wb_sel);

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++)
      rd_data[k*WIDTH +: WIDTH] = regs[rd_sel[k*SW +: SW]];
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREGS; i++) begin
      if (SYNC_RES)
        regs[i] <= RST_VAL;
      else if (pwr_en && pwr_sel == PW'(i / 2))
        regs[i] <= pwr_data[(i % 2)*WIDTH +: WIDTH];
      else if (wr_en && wr_sel == SW'(i))
        regs[i] <= wr_data;
      else if (wb_en && wb_sel == PW'(i / 2))
        regs[i] <= wb_val[(i % 2)*WIDTH +: WIDTH];
    end
  end

  regfile_idu #(
    .WIDTH(WIDTH),
    .PW   (PW)
  ) u_idu (
    .clk     (CLK),
    .sync_res(SYNC_RES),
    .idu_req (idu_req),
    .idu_sel (idu_sel),
    .idu_dec (idu_dec),
    .cap_val (cap_val),
    .wb_block(wb_block),
    .idu_busy(idu_busy),
    .idu_done(idu_done),
    .idu_drop(idu_drop),
    .idu_out (idu_out),
    .wb_en   (wb_en),
    .wb_sel  (wb_sel),
    .wb_val  (wb_val)
  );

endmodule
